seq_mult_unit: RTL and testbench

- Multi-cycle unsigned shift-add multiplier for the datapath's execute stage.
- Accepts two W-bit operands on a start strobe, iterates one multiplier bit per clock, and presents a 2W-bit product with a one-cycle done strobe.
- Its product output feeds the downstream W-wide pipeline register: the low half directly, or both halves via two instances.
- The product is held stable between operations, so the downstream register can sample it on any later edge.

---
 rtl/seq_mult_unit.sv | 112 +++++++++++
 tb/tb_seq_mult_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_unit
//  Description : Multi-cycle unsigned shift-add multiplier. Captures W-bit
//                operands on start, retires one multiplier bit per clock and
//                presents a registered 2W-bit product with a one-cycle done.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_unit #(
   parameter int W  = 32,
   parameter int CW = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             busy,
   output logic             done,
   output logic [2*W-1:0]   product
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Counter value of the final iteration.
   localparam logic [CW-1:0] C_LAST = CW'(W - 1);

   state_e           state_q,   state_d;
   logic [2*W-1:0]   acc_q,     acc_d;
   logic [2*W-1:0]   mcand_q,   mcand_d;
   logic [W-1:0]     mplier_q,  mplier_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [2*W-1:0]   product_q, product_d;
   logic [2*W-1:0]   acc_sum;

   // Accumulator value after this cycle's conditional add; the add cannot
   // overflow because the product of two W-bit values fits in 2W bits.
   always_comb begin
      acc_sum = acc_q;
      if (mplier_q[0]) begin
         acc_sum = acc_q + mcand_q;
      end
   end

   // Next-state and datapath update: load on accepted start, iterate in RUN,
   // publish the product on the last iteration, single-cycle DONE.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d  = {{W{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
               product_d = acc_sum;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Status outputs decode registered state only.
   assign busy    = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_unit
//  Description : Self-checking bench for seq_mult_unit (W=8 and W=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;

   localparam int W8  = 8;
   localparam int W32 = 32;
   localparam int PERIOD = 10;

   logic              clk;
   logic              rst_n;
   logic              start8, busy8, done8;
   logic [W8-1:0]     a8, b8;
   logic [2*W8-1:0]   prod8;
   logic              start32, busy32, done32;
   logic [W32-1:0]    a32, b32;
   logic [2*W32-1:0]  prod32;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] hold8  = '0;
   logic [63:0] hold32 = '0;
   time t_acc_prev = 0;
   time t_acc_last = 0;

   seq_mult_unit #(.W(W8), .CW(6)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   seq_mult_unit #(.W(W32), .CW(6)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .product(prod32)
   );

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge in IDLE. Ends at the negedge of the IDLE cycle
   // that follows DONE, so a further call launches the earliest legal start.
   task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input bit inject);
      logic [15:0] exp;
      int lat;
      exp = 16'(int'(ia) * int'(ib));
      start8 = 1'b1; a8 = ia; b8 = ib;
      @(posedge clk);
      t_acc_prev = t_acc_last;
      t_acc_last = $time;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!done8 && lat < W8 + 4) begin
         chk("run_busy8", 64'(busy8), 64'd1);
         chk("run_hold8", 64'(prod8), 64'(hold8));
         if (inject && lat == 3) begin
            start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start8 = 1'b0;
      chk("latency8", 64'(lat), 64'(W8));
      chk("done_busy8", 64'(busy8), 64'd0);
      chk("product8", 64'(prod8), 64'(exp));
      hold8 = exp;
      @(negedge clk);
      chk("post_done8", 64'({busy8, done8}), 64'd0);
      chk("post_hold8", 64'(prod8), 64'(hold8));
   endtask

   task automatic run_op32(input logic [31:0] ia, input logic [31:0] ib);
      logic [63:0] exp;
      int lat;
      exp = 64'(ia) * 64'(ib);
      start32 = 1'b1; a32 = ia; b32 = ib;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0; a32 = $urandom; b32 = $urandom;
      lat = 0;
      while (!done32 && lat < W32 + 4) begin
         if (lat == 5) chk("run_hold32", prod32, hold32);
         @(negedge clk);
         lat++;
      end
      chk("latency32", 64'(lat), 64'(W32));
      chk("product32", prod32, exp);
      hold32 = exp;
      @(negedge clk);
      chk("post_hold32", prod32, hold32);
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start32 = 1'b0; a32 = '0; b32 = '0;

      // Reset held for three cycles, then released away from the edge.
      repeat (3) @(negedge clk);
      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_done8", 64'(done8), 64'd0);
      chk("rst_prod8", 64'(prod8), 64'd0);
      chk("rst_prod32", prod32, 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_out8", 64'({busy8, done8, prod8}), 64'd0);
      end

      // Directed and boundary operands.
      run_op8(8'd13, 8'd11, 1'b0);
      run_op8(8'd255, 8'd255, 1'b0);
      run_op8(8'd0, 8'd200, 1'b0);
      run_op8(8'd1, 8'd128, 1'b0);

      // Start during RUN is ignored; immediate follow-up start is accepted.
      run_op8(8'd13, 8'd11, 1'b1);
      run_op8(8'd37, 8'd5, 1'b0);
      chk("start_spacing", 64'((t_acc_last - t_acc_prev) / PERIOD), 64'(W8 + 2));

      // Asynchronous reset in the middle of an operation.
      start8 = 1'b1; a8 = 8'd13; b8 = 8'd11;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy8", 64'(busy8), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy8", 64'(busy8), 64'd0);
      chk("arst_done8", 64'(done8), 64'd0);
      chk("arst_prod8", 64'(prod8), 64'd0);
      hold8 = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W8 + 2; i++) begin
         @(negedge clk);
         chk("no_done_after_rst", 64'({busy8, done8}), 64'd0);
      end
      run_op8(8'd7, 8'd6, 1'b0);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 6; i++) begin
         run_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      // Wide instance.
      run_op32(32'hFFFF_FFFF, 32'h0000_0002);
      run_op32($urandom, $urandom);
      run_op32($urandom, $urandom);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
